// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source identifiers for the common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int CDB_ID_WIDTH  = 4;
    localparam int CDB_VAL_WIDTH = 32;

    // Source identity; also used as the round-robin "last granted" pointer.
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-source result FIFO: power-of-two depth, synchronous clear, registered count.
module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign head = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; contents are don't-care while count says empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-source round-robin arbiter driving the registered common data bus.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ID_WIDTH  = CDB_ID_WIDTH,
    parameter int VAL_WIDTH = CDB_VAL_WIDTH,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 alu_valid,
    input  logic [ID_WIDTH-1:0]  alu_tag,
    input  logic [VAL_WIDTH-1:0] alu_val,
    output logic                 alu_ready,
    input  logic                 lsb_valid,
    input  logic [ID_WIDTH-1:0]  lsb_tag,
    input  logic [VAL_WIDTH-1:0] lsb_val,
    output logic                 lsb_ready,
    output logic                 cdb_valid,
    output logic [ID_WIDTH-1:0]  cdb_tag,
    output logic [VAL_WIDTH-1:0] cdb_val
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ID_WIDTH + VAL_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] alu_count, lsb_count;
    logic [EW-1:0] alu_head, lsb_head;
    logic [EW-1:0] alu_item, lsb_item;
    logic          active, clear;
    logic          alu_acc, lsb_acc, alu_empty, lsb_empty;
    logic          alu_cand, lsb_cand, grant_alu, grant_lsb;
    logic          alu_push, lsb_push, alu_pop, lsb_pop;
    cdb_src_e      last_grant, last_next;
    logic          bus_valid_next;
    logic [EW-1:0] bus_item_next;

    assign active    = rdy_in && !flush;
    assign clear     = rdy_in && flush;
    assign alu_ready = rst_in && rdy_in && (alu_count < FULL);
    assign lsb_ready = rst_in && rdy_in && (lsb_count < FULL);

    // Tag 0 is consumed at the handshake but never becomes a candidate.
    assign alu_acc   = active && alu_valid && alu_ready && (alu_tag != '0);
    assign lsb_acc   = active && lsb_valid && lsb_ready && (lsb_tag != '0);
    assign alu_empty = (alu_count == '0);
    assign lsb_empty = (lsb_count == '0);

    // Empty FIFO lets the incoming item bypass straight to arbitration.
    assign alu_cand  = active && (!alu_empty || alu_acc);
    assign lsb_cand  = active && (!lsb_empty || lsb_acc);
    assign alu_item  = alu_empty ? {alu_tag, alu_val} : alu_head;
    assign lsb_item  = lsb_empty ? {lsb_tag, lsb_val} : lsb_head;

    // A granted head pops; an accepted item pushes unless it was bypassed.
    assign alu_pop   = grant_alu && !alu_empty;
    assign lsb_pop   = grant_lsb && !lsb_empty;
    assign alu_push  = alu_acc && !(grant_alu && alu_empty);
    assign lsb_push  = lsb_acc && !(grant_lsb && lsb_empty);

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_alu_fifo (
        .clk(clk), .rst_n(rst_in), .clear(clear), .push(alu_push),
        .din({alu_tag, alu_val}), .pop(alu_pop), .head(alu_head), .count(alu_count)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_lsb_fifo (
        .clk(clk), .rst_n(rst_in), .clear(clear), .push(lsb_push),
        .din({lsb_tag, lsb_val}), .pop(lsb_pop), .head(lsb_head), .count(lsb_count)
    );

    // Round-robin grant, pointer next-state and next bus contents.
    always_comb begin
        grant_alu      = 1'b0;
        grant_lsb      = 1'b0;
        last_next      = last_grant;
        bus_valid_next = 1'b0;
        bus_item_next  = '0;
        if (alu_cand && lsb_cand) begin
            if (last_grant == CDB_SRC_LSB) grant_alu = 1'b1;
            else                           grant_lsb = 1'b1;
        end else begin
            grant_alu = alu_cand;
            grant_lsb = lsb_cand;
        end
        if (grant_alu) begin
            last_next      = CDB_SRC_ALU;
            bus_valid_next = 1'b1;
            bus_item_next  = alu_item;
        end else if (grant_lsb) begin
            last_next      = CDB_SRC_LSB;
            bus_valid_next = 1'b1;
            bus_item_next  = lsb_item;
        end
    end

    // Pointer and bus register; everything freezes while rdy_in is low.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            last_grant <= CDB_SRC_LSB;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_val    <= '0;
        end else if (rdy_in) begin
            last_grant <= last_next;
            cdb_valid  <= bus_valid_next;
            cdb_tag    <= bus_item_next[EW-1:VAL_WIDTH];
            cdb_val    <= bus_item_next[VAL_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for the CDB arbiter.
module tb_cdb_arbiter;

    localparam int IDW   = 4;
    localparam int VW    = 32;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst_in = 1'b0;
    logic           rdy_in = 1'b1;
    logic           flush = 1'b0;
    logic           alu_valid = 1'b0;
    logic [IDW-1:0] alu_tag = '0;
    logic [VW-1:0]  alu_val = '0;
    logic           alu_ready;
    logic           lsb_valid = 1'b0;
    logic [IDW-1:0] lsb_tag = '0;
    logic [VW-1:0]  lsb_val = '0;
    logic           lsb_ready;
    logic           cdb_valid;
    logic [IDW-1:0] cdb_tag;
    logic [VW-1:0]  cdb_val;

    typedef struct {
        logic [IDW-1:0] tag;
        logic [VW-1:0]  val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.ID_WIDTH(IDW), .VAL_WIDTH(VW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic expect_bcast(input int t, input int v);
        exp_t e;
        e.tag = IDW'(t);
        e.val = VW'(v);
        exp_q.push_back(e);
    endtask

    // One clock; at the following falling edge compare any new broadcast with the scoreboard.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (rst_in && rdy_in) begin
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bcast", {60'd0, cdb_tag}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bcast_tag", 64'(cdb_tag), 64'(e.tag));
                    chk("bcast_val", 64'(cdb_val), 64'(e.val));
                end
            end else begin
                chk("idle_tag", 64'(cdb_tag), 64'd0);
                chk("idle_val", 64'(cdb_val), 64'd0);
            end
        end
    endtask

    task automatic drive_alu(input logic v, input int t, input int val);
        alu_valid = v;
        alu_tag   = IDW'(t);
        alu_val   = VW'(val);
    endtask

    task automatic drive_lsb(input logic v, input int t, input int val);
        lsb_valid = v;
        lsb_tag   = IDW'(t);
        lsb_val   = VW'(val);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_val", 64'(cdb_val), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_lsb_ready", 64'(lsb_ready), 64'd0);
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    initial begin
        int  ai;
        int  li;
        logic ra;
        logic rl;

        // Reset from time zero.
        do_reset();
        #1;
        chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("post_rst_lsb_ready", 64'(lsb_ready), 64'd1);

        // Collision with pointer at reset value: ALU first, LSB next.
        expect_bcast(2, 'hA);
        expect_bcast(5, 'hB);
        drive_alu(1'b1, 2, 'hA);
        drive_lsb(1'b1, 5, 'hB);
        cycle();
        chk("col_first_tag", 64'(cdb_tag), 64'd2);
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        cycle();
        chk("col_second_tag", 64'(cdb_tag), 64'd5);
        cycle();

        // Single ALU result: one-cycle bypass, exactly one broadcast cycle.
        expect_bcast(3, 'h11);
        drive_alu(1'b1, 3, 'h11);
        cycle();
        chk("alu_only_valid", 64'(cdb_valid), 64'd1);
        drive_alu(1'b0, 0, 0);
        cycle();
        chk("alu_only_idle", 64'(cdb_valid), 64'd0);

        // Both producers saturated (pointer last = ALU): strict L/A alternation, back-pressure.
        for (int i = 1; i <= 6; i++) begin
            expect_bcast(8 + i, 'h200 + 8 + i);
            expect_bcast(i, 'h100 + i);
        end
        ai = 1;
        li = 1;
        for (int it = 1; it <= 30 && (ai <= 6 || li <= 6); it++) begin
            drive_alu(ai <= 6, ai, 'h100 + ai);
            drive_lsb(li <= 6, 8 + li, 'h200 + 8 + li);
            ra = alu_ready;
            rl = lsb_ready;
            cycle();
            if (alu_valid && ra) ai++;
            if (lsb_valid && rl) li++;
            if (it == 3) begin
                chk("bp_alu_full_ready", 64'(alu_ready), 64'd0);
                chk("bp_lsb_ready_e3", 64'(lsb_ready), 64'd1);
            end
            if (it == 4) begin
                chk("bp_alu_ready_e4", 64'(alu_ready), 64'd1);
                chk("bp_lsb_full_ready", 64'(lsb_ready), 64'd0);
            end
        end
        chk("bp_alu_all_accepted", 64'(ai), 64'd7);
        chk("bp_lsb_all_accepted", 64'(li), 64'd7);
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        repeat (8) cycle();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Flush with entries queued: queued tags 3, 10, 11 must never appear.
        do_reset();
        expect_bcast(1, 'h101);
        expect_bcast(9, 'h209);
        expect_bcast(2, 'h102);
        for (int i = 1; i <= 3; i++) begin
            drive_alu(1'b1, i, 'h100 + i);
            drive_lsb(1'b1, 8 + i, 'h200 + 8 + i);
            cycle();
        end
        chk("pre_flush_alu_ready", 64'(alu_ready), 64'd1);
        chk("pre_flush_lsb_ready", 64'(lsb_ready), 64'd0);
        drive_alu(1'b1, 4, 'h104);
        drive_lsb(1'b1, 12, 'h20C);
        flush = 1'b1;
        cycle();
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_alu_ready", 64'(alu_ready), 64'd1);
        chk("flush_lsb_ready", 64'(lsb_ready), 64'd1);
        flush = 1'b0;
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        repeat (3) cycle();
        // Pointer survives the flush (last = ALU), so LSB wins this collision.
        expect_bcast(13, 'h20D);
        expect_bcast(5, 'h105);
        drive_alu(1'b1, 5, 'h105);
        drive_lsb(1'b1, 13, 'h20D);
        cycle();
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        repeat (2) cycle();

        // Stall: held broadcast, no accept, flush ignored while rdy_in is low.
        expect_bcast(4, 'h44);
        drive_alu(1'b1, 4, 'h44);
        cycle();
        rdy_in = 1'b0;
        flush  = 1'b1;
        drive_alu(1'b1, 6, 'h66);
        drive_lsb(1'b1, 7, 'h77);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_valid", 64'(cdb_valid), 64'd1);
            chk("stall_tag", 64'(cdb_tag), 64'd4);
            chk("stall_val", 64'(cdb_val), 64'h44);
            chk("stall_alu_ready", 64'(alu_ready), 64'd0);
        end
        flush  = 1'b0;
        rdy_in = 1'b1;
        expect_bcast(7, 'h77);
        expect_bcast(6, 'h66);
        cycle();
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        repeat (2) cycle();

        // Tag 0 is consumed but never broadcast.
        drive_alu(1'b1, 0, 'h99);
        cycle();
        chk("tag0_drop", 64'(cdb_valid), 64'd0);
        drive_alu(1'b0, 0, 0);
        cycle();

        // Reset mid-queue: ALU tag 1 is left queued and must vanish.
        expect_bcast(9, 'h909);
        drive_alu(1'b1, 1, 'h901);
        drive_lsb(1'b1, 9, 'h909);
        cycle();
        drive_alu(1'b0, 0, 0);
        drive_lsb(1'b0, 0, 0);
        #2;
        do_reset();
        #1;
        chk("rel_alu_ready", 64'(alu_ready), 64'd1);
        chk("rel_lsb_ready", 64'(lsb_ready), 64'd1);
        repeat (3) cycle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
